// File: rtl/zigbee_mux_pkg.sv
// Shared definitions for the zigbee multiplexed test-pin host driver.
// Holds the default bus widths, the FSM state type and the vector typedefs
// used by the interface, the driver and its bench.
package zigbee_mux_pkg;

  localparam int unsigned IN_W_DEF  = 22;
  localparam int unsigned OUT_W_DEF = 18;
  localparam int unsigned SEL_W_DEF = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSamp1,
    StSamp2,
    StResp
  } state_e;

  typedef logic [IN_W_DEF-1:0]  in_vec_t;
  typedef logic [OUT_W_DEF-1:0] out_vec_t;
  typedef logic [SEL_W_DEF-1:0] sel_vec_t;

endpackage

// File: rtl/zigbee_mux_host_if.sv
// Request/response handshake bundle for zigbee_mux_host.
//   master : request producer / response consumer (tester software side)
//   slave  : the pin driver itself
// req_* : valid/ready request (rd flag, select, data to drive)
// rsp_* : valid/ready response for reads (captured data, select, error)
interface zigbee_mux_host_if
  import zigbee_mux_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
);

  logic             req_valid;
  logic             req_ready;
  logic             req_rd;
  logic [SEL_W-1:0] req_sel;
  logic [IN_W-1:0]  req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic [SEL_W-1:0] rsp_sel;
  logic             rsp_err;

  modport master (
    output req_valid, req_rd, req_sel, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_sel, rsp_err
  );

  modport slave (
    input  req_valid, req_rd, req_sel, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_sel, rsp_err
  );

endinterface

// File: rtl/zigbee_sync2.sv
// Two-flop synchroniser for a bus arriving asynchronously to i_clk.
// Ports:
//   i_clk    : destination clock
//   i_resetn : synchronous active-low reset, clears both stages to 0
//   i_d      : asynchronous input bus
//   o_q      : synchronised bus, two cycles of latency
module zigbee_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/zigbee_mux_host.sv
// Host-side driver for the zigbee multiplexed test pins.
// Each accepted request drives sel/in onto the pads, holds them for SETTLE_CYC
// cycles and, for reads, double-samples the synchronised out bus, retrying up
// to MAX_RETRY times on disagreement before returning the value with an error.
// Ports:
//   clk_i     : single clock
//   resetn_i  : synchronous active-low reset; aborts any transaction
//   bus       : request/response handshake (slave modport)
//   pad_sel_o : registered select to chip sel pins
//   pad_in_o  : registered data to chip in pins
//   pad_out_i : chip out pins, asynchronous to clk_i
//   busy_o    : high whenever a transaction is in flight
module zigbee_mux_host
  import zigbee_mux_pkg::*;
#(
  parameter int unsigned IN_W       = IN_W_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned SEL_W      = SEL_W_DEF,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  zigbee_mux_host_if.slave     bus,
  output logic [SEL_W-1:0]     pad_sel_o,
  output logic [IN_W-1:0]      pad_in_o,
  input  logic [OUT_W-1:0]     pad_out_i,
  output logic                 busy_o
);

  // Widths sized so the loaded values fit exactly; floor of 1 bit keeps
  // degenerate parameter choices legal.
  localparam int unsigned CntW   = (SETTLE_CYC + 1 > 2) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int unsigned RetryW = (MAX_RETRY + 1 > 2) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CntW-1:0]   CntLoad  = CntW'(SETTLE_CYC - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [RetryW-1:0] r_retry;
  logic              r_rd;
  logic [SEL_W-1:0]  r_pad_sel;
  logic [IN_W-1:0]   r_pad_in;
  logic [OUT_W-1:0]  r_s1;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [OUT_W-1:0]  r_rsp_data;
  logic [SEL_W-1:0]  r_rsp_sel;
  logic              r_rsp_err;
  logic [OUT_W-1:0]  w_out_sync;

  zigbee_sync2 #(
    .WIDTH (OUT_W)
  ) u_out_sync (
    .i_clk    (clk_i),
    .i_resetn (resetn_i),
    .i_d      (pad_out_i),
    .o_q      (w_out_sync)
  );

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_rd        <= 1'b0;
      r_pad_sel   <= '0;
      r_pad_in    <= '0;
      r_s1        <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_sel   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.req_valid && r_req_ready) begin
            r_pad_sel   <= bus.req_sel;
            r_pad_in    <= bus.req_data;
            r_rd        <= bus.req_rd;
            r_cnt       <= CntLoad;
            r_retry     <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= StSettle;
          end
        end
        StSettle: begin
          if (r_cnt == '0) begin
            if (r_rd) begin
              r_state <= StSamp1;
            end else begin
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StSamp1: begin
          r_s1    <= w_out_sync;
          r_state <= StSamp2;
        end
        StSamp2: begin
          // Two consecutive equal samples mean the pads have settled.
          if (w_out_sync == r_s1) begin
            r_rsp_data  <= r_s1;
            r_rsp_sel   <= r_pad_sel;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else if (r_retry < RetryMax) begin
            r_retry <= r_retry + 1'b1;
            r_cnt   <= CntLoad;
            r_state <= StSettle;
          end else begin
            r_rsp_data  <= w_out_sync;
            r_rsp_sel   <= r_pad_sel;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_sel   = r_rsp_sel;
  assign bus.rsp_err   = r_rsp_err;
  assign pad_sel_o     = r_pad_sel;
  assign pad_in_o      = r_pad_in;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_zigbee_mux_host.sv
// Self-checking bench for zigbee_mux_host (SETTLE_CYC=4, MAX_RETRY=3).
module tb_zigbee_mux_host;
  import zigbee_mux_pkg::*;

  logic     clk = 1'b0;
  logic     resetn = 1'b0;
  out_vec_t pad_static = '0;
  out_vec_t tog_val = 18'h00001;
  logic     toggle_en = 1'b0;
  out_vec_t pad_out;
  sel_vec_t pad_sel;
  in_vec_t  pad_in;
  logic     busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) tog_val <= (tog_val == 18'h00001) ? 18'h00002 : 18'h00001;

  assign pad_out = toggle_en ? tog_val : pad_static;

  zigbee_mux_host_if u_if ();

  zigbee_mux_host #(
    .SETTLE_CYC (4),
    .MAX_RETRY  (3)
  ) u_dut (
    .clk_i     (clk),
    .resetn_i  (resetn),
    .bus       (u_if.slave),
    .pad_sel_o (pad_sel),
    .pad_in_o  (pad_in),
    .pad_out_i (pad_out),
    .busy_o    (busy)
  );

  typedef struct {
    logic     rd;
    sel_vec_t sel;
    in_vec_t  data;
    out_vec_t pad;
    out_vec_t exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Request must already be driven; returns the handshake edge index.
  task automatic accept(output int t0);
    int n = 0;
    while (!u_if.req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_before_accept", u_if.req_ready, 1);
    tick();
    t0 = cyc - 1;
  endtask

  task automatic wait_rsp(input int t0, output int lat);
    int n = 0;
    while (!u_if.rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("rsp_seen", u_if.rsp_valid, 1);
    lat = cyc - t0;
  endtask

  task automatic drive_req(input logic rd, input sel_vec_t sel, input in_vec_t data);
    u_if.req_valid = 1'b1;
    u_if.req_rd    = rd;
    u_if.req_sel   = sel;
    u_if.req_data  = data;
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    pad_static = v.pad;
    toggle_en  = 1'b0;
    u_if.rsp_ready = 1'b1;
    drive_req(v.rd, v.sel, v.data);
    accept(t0);
    u_if.req_valid = 1'b0;
    chk("vec_pad_sel", pad_sel, v.sel);
    chk("vec_pad_in", pad_in, v.data);
    chk("vec_busy", busy, 1);
    chk("vec_ready_low", u_if.req_ready, 0);
    if (!v.rd) begin
      for (int i = 2; i <= 4; i++) begin
        tick();
        chk("wr_ready_low", u_if.req_ready, 0);
        chk("wr_no_rsp", u_if.rsp_valid, 0);
      end
      tick();
      chk("wr_ready_high_t5", u_if.req_ready, 1);
      chk("wr_busy_clear", busy, 0);
      chk("wr_no_rsp_end", u_if.rsp_valid, 0);
      chk("wr_pad_hold", pad_in, v.data);
    end else begin
      for (int i = 2; i <= 6; i++) begin
        tick();
        chk("rd_no_early_rsp", u_if.rsp_valid, 0);
      end
      tick();
      chk("rd_rsp_t7", u_if.rsp_valid, 1);
      chk("rd_rsp_data", u_if.rsp_data, v.exp_data);
      chk("rd_rsp_sel", u_if.rsp_sel, v.sel);
      chk("rd_rsp_err", u_if.rsp_err, 0);
      tick();
      chk("rd_rsp_one_cycle", u_if.rsp_valid, 0);
      chk("rd_ready_back", u_if.req_ready, 1);
    end
  endtask

  initial begin
    int t0;
    int t1;
    int lat;

    vecs[0] = '{rd: 1'b0, sel: 2'd2, data: 22'h2A5A5A, pad: 18'h00000, exp_data: 18'h00000};
    vecs[1] = '{rd: 1'b1, sel: 2'd1, data: 22'h000000, pad: 18'h3C0F3, exp_data: 18'h3C0F3};
    vecs[2] = '{rd: 1'b0, sel: 2'd3, data: 22'h3FFFFF, pad: 18'h3FFFF, exp_data: 18'h00000};
    vecs[3] = '{rd: 1'b1, sel: 2'd0, data: 22'h155555, pad: 18'h3FFFF, exp_data: 18'h3FFFF};
    vecs[4] = '{rd: 1'b1, sel: 2'd2, data: 22'h0ABCDE, pad: 18'h00000, exp_data: 18'h00000};
    vecs[5] = '{rd: 1'b0, sel: 2'd0, data: 22'h000000, pad: 18'h12345, exp_data: 18'h00000};

    // Reset with a request held on the bus.
    resetn = 1'b0;
    u_if.rsp_ready = 1'b0;
    drive_req(1'b0, 2'd3, 22'h3FFFFF);
    repeat (3) tick();
    chk("rst_pad_sel", pad_sel, 0);
    chk("rst_pad_in", pad_in, 0);
    chk("rst_rsp_valid", u_if.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    u_if.req_valid = 1'b0;
    resetn = 1'b1;
    tick();
    chk("post_rst_ready", u_if.req_ready, 1);
    chk("post_rst_pad_in", pad_in, 0);

    // Table-driven transactions.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Response held under back-pressure.
    pad_static = 18'h3C0F3;
    u_if.rsp_ready = 1'b0;
    drive_req(1'b1, 2'd1, 22'h015555);
    accept(t0);
    u_if.req_valid = 1'b0;
    wait_rsp(t0, lat);
    chk("bp_latency", lat, 7);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", u_if.rsp_valid, 1);
      chk("bp_data_hold", u_if.rsp_data, 18'h3C0F3);
      chk("bp_sel_hold", u_if.rsp_sel, 1);
      chk("bp_err_hold", u_if.rsp_err, 0);
      chk("bp_ready_low", u_if.req_ready, 0);
      tick();
    end
    chk("bp_valid_last", u_if.rsp_valid, 1);
    u_if.rsp_ready = 1'b1;
    tick();
    chk("bp_valid_drop", u_if.rsp_valid, 0);
    chk("bp_ready_back", u_if.req_ready, 1);

    // Never-settling out bus: four sample pairs then error.
    toggle_en = 1'b1;
    repeat (3) tick();
    drive_req(1'b1, 2'd3, 22'h0ABCDE);
    accept(t0);
    u_if.req_valid = 1'b0;
    wait_rsp(t0, lat);
    chk("retry_err_latency", lat, 25);
    chk("retry_err_flag", u_if.rsp_err, 1);
    chk("retry_err_data", (u_if.rsp_data == 18'h00001) || (u_if.rsp_data == 18'h00002), 1);
    chk("retry_err_sel", u_if.rsp_sel, 3);
    tick();
    chk("retry_err_drop", u_if.rsp_valid, 0);

    // Bus settles during the second settle window.
    drive_req(1'b1, 2'd2, 22'h000111);
    accept(t0);
    u_if.req_valid = 1'b0;
    repeat (6) tick();
    toggle_en  = 1'b0;
    pad_static = 18'h00055;
    wait_rsp(t0, lat);
    chk("retry_ok_latency", lat, 13);
    chk("retry_ok_err", u_if.rsp_err, 0);
    chk("retry_ok_data", u_if.rsp_data, 18'h00055);
    tick();

    // Back-to-back write then read with valid held.
    pad_static = 18'h2D2D2;
    drive_req(1'b0, 2'd2, 22'h111111);
    accept(t0);
    chk("b2b_pad_wr_sel", pad_sel, 2);
    chk("b2b_pad_wr_in", pad_in, 22'h111111);
    drive_req(1'b1, 2'd1, 22'h222222);
    accept(t1);
    u_if.req_valid = 1'b0;
    chk("b2b_second_accept", t1 - t0, 5);
    chk("b2b_pad_rd_sel", pad_sel, 1);
    chk("b2b_pad_rd_in", pad_in, 22'h222222);
    wait_rsp(t1, lat);
    chk("b2b_rd_latency", lat, 7);
    chk("b2b_rd_data", u_if.rsp_data, 18'h2D2D2);
    chk("b2b_rd_sel", u_if.rsp_sel, 1);
    tick();

    // Reset while in RESP.
    u_if.rsp_ready = 1'b0;
    drive_req(1'b1, 2'd3, 22'h3A3A3A);
    accept(t0);
    u_if.req_valid = 1'b0;
    wait_rsp(t0, lat);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst_resp_valid", u_if.rsp_valid, 0);
    chk("rst_resp_pad_sel", pad_sel, 0);
    chk("rst_resp_pad_in", pad_in, 0);
    chk("rst_resp_busy", busy, 0);
    u_if.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_resp_no_rsp", u_if.rsp_valid, 0);
    end

    // Reset while in SETTLE, then a normal write.
    drive_req(1'b0, 2'd1, 22'h0F0F0F);
    accept(t0);
    u_if.req_valid = 1'b0;
    tick();
    chk("settle_busy", busy, 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst_settle_pad_in", pad_in, 0);
    chk("rst_settle_pad_sel", pad_sel, 0);
    chk("rst_settle_busy", busy, 0);
    tick();
    chk("rst_settle_ready", u_if.req_ready, 1);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zigbee_mux_host.md
Name: zigbee_mux_host

Overview:
Host-side driver for the zigbee platform's multiplexed test pins: sel (2b), in (22b, into the chip) and out (18b, from the chip). The block turns a valid/ready request stream into pin activity. For each request it drives sel and in, waits a programmable settle time, and for reads double-samples the synchronised out bus before returning it on a valid/ready response stream. It sits in the FPGA/tester platform opposite the chip pad ring.

Parameters:
IN_W, 22, width of chip input mux bus driven by this block
OUT_W, 18, width of chip output mux bus sampled by this block
SEL_W, 2, width of mux select
SETTLE_CYC, 4, cycles pads are held before sampling or completing (legal range 1..255)
MAX_RETRY, 3, extra settle/sample attempts on sample mismatch before flagging error

Ports:
clk_i  in  1  single clock
resetn_i  in  1  reset, synchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_rd_i  in  1  1 = drive then capture out bus; 0 = drive only
req_sel_i  in  SEL_W  select value to drive
req_data_i  in  IN_W  data to drive on in pins
rsp_valid_o  out  1  response valid (read requests only)
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  OUT_W  captured out-bus value
rsp_sel_o  out  SEL_W  select used for this capture
rsp_err_o  out  1  samples never matched within MAX_RETRY
pad_sel_o  out  SEL_W  to chip sel pins (registered)
pad_in_o  out  IN_W  to chip in pins (registered)
pad_out_i  in  OUT_W  from chip out pins, asynchronous to clk_i
busy_o  out  1  state != IDLE

Behaviour:
- Reset (resetn_i low at a clock edge): state IDLE. All outputs are 0 except req_ready_o, which is 1 from the first cycle after reset. Synchroniser flops, sample, counter and retry registers are cleared. Reset mid-transaction aborts it without a response; pads return to 0.
- pad_out_i passes through a 2-flop synchroniser (out_sync) before any use.
- States: IDLE, SETTLE, SAMP1, SAMP2, RESP.
- IDLE: req_ready_o=1. On handshake at edge T:
  - latch sel/data into pad_sel_o/pad_in_o, visible from T+1;
  - latch req_rd_i and sel;
  - cnt=SETTLE_CYC-1, retry=0;
  - go to SETTLE.
- SETTLE: req_ready_o=0. Decrement cnt each cycle. At cnt==0: go to SAMP1 if rd, else go to IDLE. A write therefore accepts its next request no earlier than T+SETTLE_CYC+1.
- SAMP1: s1 <= out_sync; go to SAMP2.
- SAMP2:
  - out_sync==s1: rsp_data_o<=s1, rsp_err_o<=0, go to RESP.
  - mismatch and retry<MAX_RETRY: retry++, cnt=SETTLE_CYC-1, go to SETTLE.
  - mismatch and retry==MAX_RETRY: rsp_data_o<=out_sync, rsp_err_o<=1, go to RESP.
- RESP: rsp_valid_o=1 with data, sel and err stable until rsp_ready_i. On handshake go to IDLE; rsp_valid_o drops the next cycle.
- Clean-read latency: rsp_valid_o first high at T+SETTLE_CYC+3.
- Pads hold the last driven value between transactions. They change only on an IDLE handshake or on reset.
- Requests arriving while not IDLE are not accepted (ready low); req_* is sampled only at the handshake edge.
- rsp_ready_i held high: response lasts exactly 1 cycle. It is ignored outside RESP.
- No req/rsp overlap: one outstanding transaction maximum.
- Counter width clog2(SETTLE_CYC+1); retry width clog2(MAX_RETRY+1); no wrap-around possible.

Decomposition:
- Package zigbee_mux_pkg:
  - IN_W/OUT_W/SEL_W defaults;
  - state enum (IDLE, SETTLE, SAMP1, SAMP2, RESP);
  - typedefs for in/out/sel vectors.
- Sub-module zigbee_sync2: parameterised-width 2-flop synchroniser, synchronous active-low reset to 0, used for pad_out_i.
- FSM, counter and pad registers stay in zigbee_mux_host.

Test Plan:
1. Reset with req_valid_i=1 held: all pads 0, rsp_valid_o=0, no acceptance during reset; ready=1 the first cycle after release.
2. Write sel=2'b10, data=22'h2A5A5A, SETTLE_CYC=4, handshake at T:
   - pads show 2/22'h2A5A5A from T+1;
   - ready low T+1..T+4, high at T+5;
   - no rsp_valid_o.
3. Read sel=1 with pad_out_i static 18'h3C0F3: rsp_valid_o at T+7, data=18'h3C0F3, sel=1, err=0. With rsp_ready_i low for 5 cycles, outputs are held unchanged, then drop the cycle after the handshake.
4. Read with pad_out_i toggling between 18'h00001 and 18'h00002 every cycle: 4 sample pairs, then rsp_err_o=1. Change pad_out_i to stable 18'h00055 during the 2nd settle: err=0, data=18'h00055.
5. Back-to-back: write then read with req_valid_i held continuously. Second accept occurs exactly at T+5, pads update once per request, and the read response matches pad_out_i.
6. Assert reset while in RESP and while in SETTLE: no response emitted, pads go to 0, next request after release behaves as in scenario 2.
